// File: rtl/hazard_if.sv
// Datapath <-> hazard controller signal bundle for the 5-stage pipeline.
// master = datapath side, slave = hazard_ctrl side.
interface hazard_if #(
   parameter int unsigned CNT_W = 32
);
   logic [4:0]       rd_addr1d;
   logic [4:0]       rd_addr2d;
   logic [4:0]       rd_addr1e;
   logic [4:0]       rd_addr2e;
   logic [4:0]       wr_addre;
   logic [1:0]       result_sgne;
   logic [4:0]       wr_addrm;
   logic             regwr_sgnm;
   logic [4:0]       wr_addrw;
   logic             regwr_sgnw;
   logic             pcsrce;
   logic             mem_req_m;
   logic             mem_ready;

   logic [1:0]       fwd_ae;
   logic [1:0]       fwd_be;
   logic             stallf;
   logic             stalld;
   logic             stalle;
   logic             stallm;
   logic             flushd;
   logic             flushe;
   logic             flushw;
   logic             mem_abort;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output rd_addr1d, rd_addr2d, rd_addr1e, rd_addr2e, wr_addre, result_sgne,
             wr_addrm, regwr_sgnm, wr_addrw, regwr_sgnw, pcsrce, mem_req_m, mem_ready,
      input  fwd_ae, fwd_be, stallf, stalld, stalle, stallm, flushd, flushe, flushw,
             mem_abort, mem_err, stall_cnt, flush_cnt
   );

   modport slave (
      input  rd_addr1d, rd_addr2d, rd_addr1e, rd_addr2e, wr_addre, result_sgne,
             wr_addrm, regwr_sgnm, wr_addrw, regwr_sgnw, pcsrce, mem_req_m, mem_ready,
      output fwd_ae, fwd_be, stallf, stalld, stalle, stallm, flushd, flushe, flushw,
             mem_abort, mem_err, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Forwarding, load-use stall, redirect flush and memory-wait freeze control
// for the 5-stage pipeline, with stall/flush event counters.
module hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input logic    clk,
   input logic    rst,
   hazard_if.slave hz
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);

   typedef enum logic {RUN, MEMWAIT} state_t;

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic               mem_abort_q, mem_abort_d;
   logic               mem_err_q, mem_err_d;
   logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;

   logic               lwstall;
   logic               memstall;

   // M stage has priority: it holds the younger result for the same register.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic       wr_m, input logic [4:0] rd_m,
                                          input logic       wr_w, input logic [4:0] rd_w);
      if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
      else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
      else                                         return 2'b00;
   endfunction

   assign lwstall  = (hz.result_sgne == 2'b01) && (hz.wr_addre != 5'd0) &&
                     ((hz.wr_addre == hz.rd_addr1d) || (hz.wr_addre == hz.rd_addr2d));
   assign memstall = hz.mem_req_m && !hz.mem_ready && !mem_abort_q;

   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred on any path.
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_abort_d = 1'b0;
      mem_err_d   = mem_err_q;
      hz.fwd_ae   = 2'b00;
      hz.fwd_be   = 2'b00;
      hz.stallf   = 1'b0;
      hz.stalld   = 1'b0;
      hz.stalle   = 1'b0;
      hz.stallm   = 1'b0;
      hz.flushd   = 1'b0;
      hz.flushe   = 1'b0;
      hz.flushw   = 1'b0;

      unique case (state_q)
         RUN: begin
            if (memstall) begin
               state_d    = MEMWAIT;
               wait_cnt_d = WAIT_W'(1);
            end
         end
         MEMWAIT: begin
            if (!memstall) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_MAX) begin
               state_d     = RUN;
               wait_cnt_d  = '0;
               mem_abort_d = 1'b1;
               mem_err_d   = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase

      if (rst) begin
         hz.flushd = 1'b1;
         hz.flushe = 1'b1;
      end else begin
         hz.fwd_ae = fwd_sel(hz.rd_addr1e, hz.regwr_sgnm, hz.wr_addrm, hz.regwr_sgnw, hz.wr_addrw);
         hz.fwd_be = fwd_sel(hz.rd_addr2e, hz.regwr_sgnm, hz.wr_addrm, hz.regwr_sgnw, hz.wr_addrw);
         if (memstall) begin
            // Freeze wins over redirect; stalle keeps pcsrce alive until release.
            hz.stallf = 1'b1;
            hz.stalld = 1'b1;
            hz.stalle = 1'b1;
            hz.stallm = 1'b1;
            hz.flushw = 1'b1;
         end else begin
            hz.stallf = lwstall;
            hz.stalld = lwstall;
            hz.flushe = lwstall | hz.pcsrce;
            hz.flushd = hz.pcsrce;
         end
      end
   end

   // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         mem_abort_q <= 1'b0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_abort_q <= mem_abort_d;
         mem_err_q   <= mem_err_d;
         if (hz.stallf) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (hz.flushe) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign hz.mem_abort = mem_abort_q;
   assign hz.mem_err   = mem_err_q;
   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: forwarding, load-use, redirect,
// memory wait, timeout abort and mid-wait reset.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_frz;

   always #5 clk = ~clk;

   hazard_if #(.CNT_W(32)) hif ();

   hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .hz  (hif.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts consecutive freeze cycles until stallf drops; bounded at 40 cycles.
   task automatic count_freeze(output int n);
      n = 0;
      while (hif.stallf && n < 40) begin
         n++;
         tick();
      end
   endtask

   initial begin
      hif.rd_addr1d = 0; hif.rd_addr2d = 0; hif.rd_addr1e = 0; hif.rd_addr2e = 0;
      hif.wr_addre = 0; hif.result_sgne = 0; hif.wr_addrm = 0; hif.regwr_sgnm = 0;
      hif.wr_addrw = 0; hif.regwr_sgnw = 0; hif.pcsrce = 0; hif.mem_req_m = 0;
      hif.mem_ready = 0;

      tick(); tick();
      check("rst_flushd", hif.flushd, 1);
      check("rst_flushe", hif.flushe, 1);
      check("rst_stallf", hif.stallf, 0);
      rst = 1'b0;
      #1;
      check("init_stall_cnt", hif.stall_cnt, 0);
      check("init_flush_cnt", hif.flush_cnt, 0);
      check("init_mem_err", hif.mem_err, 0);
      check("init_mem_abort", hif.mem_abort, 0);
      check("init_flushe", hif.flushe, 0);

      // Forwarding
      hif.regwr_sgnm = 1; hif.wr_addrm = 5; hif.rd_addr1e = 5;
      hif.regwr_sgnw = 1; hif.wr_addrw = 5; hif.rd_addr2e = 9;
      #1;
      check("fwd_ae_m", hif.fwd_ae, 2'b10);
      check("fwd_be_none", hif.fwd_be, 2'b00);
      hif.regwr_sgnm = 0;
      #1;
      check("fwd_ae_w", hif.fwd_ae, 2'b01);
      hif.regwr_sgnm = 1; hif.wr_addrm = 0; hif.wr_addrw = 0; hif.rd_addr1e = 0;
      #1;
      check("fwd_ae_x0", hif.fwd_ae, 2'b00);
      hif.wr_addrw = 3; hif.rd_addr2e = 3;
      #1;
      check("fwd_be_w", hif.fwd_be, 2'b01);
      hif.regwr_sgnm = 0; hif.regwr_sgnw = 0; hif.wr_addrw = 0;
      hif.rd_addr2e = 0;

      // Load-use stall
      tick();
      hif.result_sgne = 2'b01; hif.wr_addre = 7; hif.rd_addr2d = 7;
      #1;
      check("lw_stallf", hif.stallf, 1);
      check("lw_stalld", hif.stalld, 1);
      check("lw_flushe", hif.flushe, 1);
      check("lw_flushd", hif.flushd, 0);
      check("lw_stalle", hif.stalle, 0);
      tick();
      hif.result_sgne = 2'b00; hif.wr_addre = 0; hif.rd_addr2d = 0;
      #1;
      check("lw_clear_stallf", hif.stallf, 0);
      check("lw_clear_flushe", hif.flushe, 0);
      check("lw_stall_cnt", hif.stall_cnt, 1);
      // rd=0 load never stalls
      hif.result_sgne = 2'b01; hif.wr_addre = 0; hif.rd_addr1d = 0;
      #1;
      check("lw_x0_stallf", hif.stallf, 0);
      hif.result_sgne = 2'b00;

      // Redirect flush
      tick();
      hif.pcsrce = 1;
      #1;
      check("br_flushd", hif.flushd, 1);
      check("br_flushe", hif.flushe, 1);
      check("br_stallf", hif.stallf, 0);
      tick();
      hif.pcsrce = 0;
      #1;
      check("br_flush_cnt", hif.flush_cnt, 2);

      // Memory wait 3 cycles, redirect held across the freeze
      hif.mem_req_m = 1; hif.mem_ready = 0;
      #1;
      check("mw1_stallf", hif.stallf, 1);
      check("mw1_stalle", hif.stalle, 1);
      check("mw1_stallm", hif.stallm, 1);
      check("mw1_flushw", hif.flushw, 1);
      check("mw1_flushe", hif.flushe, 0);
      tick();
      hif.pcsrce = 1;
      #1;
      check("mw2_stallm", hif.stallm, 1);
      check("mw2_flushd_masked", hif.flushd, 0);
      check("mw2_flushe_masked", hif.flushe, 0);
      tick();
      #1;
      check("mw3_stallf", hif.stallf, 1);
      tick();
      hif.mem_ready = 1;
      #1;
      check("mw_rel_stallf", hif.stallf, 0);
      check("mw_rel_stallm", hif.stallm, 0);
      check("mw_rel_flushw", hif.flushw, 0);
      check("mw_rel_flushd", hif.flushd, 1);
      check("mw_rel_flushe", hif.flushe, 1);
      tick();
      hif.mem_req_m = 0; hif.mem_ready = 0; hif.pcsrce = 0;
      #1;
      check("mw_mem_err", hif.mem_err, 0);
      check("mw_stall_cnt", hif.stall_cnt, 4);
      check("mw_flush_cnt", hif.flush_cnt, 3);

      // Timeout: 16 freeze cycles, then abort pulse with stall masked
      hif.mem_req_m = 1;
      #1;
      count_freeze(n_frz);
      check("to_freeze_cycles", n_frz, 16);
      check("to_abort_pulse", hif.mem_abort, 1);
      check("to_abort_unmasked", hif.stallm, 0);
      tick();
      hif.mem_req_m = 0;
      #1;
      check("to_abort_end", hif.mem_abort, 0);
      check("to_mem_err", hif.mem_err, 1);
      check("to_stall_cnt", hif.stall_cnt, 20);
      tick();
      #1;
      check("to_mem_err_sticky", hif.mem_err, 1);

      // Reset in the middle of a memory wait
      hif.mem_req_m = 1;
      tick(); tick();
      rst = 1;
      hif.regwr_sgnm = 1; hif.wr_addrm = 5; hif.rd_addr1e = 5;
      #1;
      check("mrst_fwd_ae", hif.fwd_ae, 2'b00);
      check("mrst_flushd", hif.flushd, 1);
      check("mrst_flushe", hif.flushe, 1);
      check("mrst_stallm", hif.stallm, 0);
      tick();
      rst = 0;
      hif.mem_req_m = 0; hif.regwr_sgnm = 0; hif.wr_addrm = 0; hif.rd_addr1e = 0;
      #1;
      check("mrst_stall_cnt", hif.stall_cnt, 0);
      check("mrst_flush_cnt", hif.flush_cnt, 0);
      check("mrst_mem_err", hif.mem_err, 0);
      check("mrst_flushd_off", hif.flushd, 0);
      hif.mem_req_m = 1;
      #1;
      count_freeze(n_frz);
      check("mrst_fresh_timeout", n_frz, 16);
      check("mrst_abort", hif.mem_abort, 1);
      hif.mem_req_m = 0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
